// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle core: opcodes, FSM states, instruction fields.
// No logic; constants and types only.
// Not applicable (no handshake).
package cpu_pkg;

    localparam logic [3:0] OP_NOP       = 4'd0;
    localparam logic [3:0] OP_LI        = 4'd1;
    localparam logic [3:0] OP_LOAD      = 4'd2;
    localparam logic [3:0] OP_STORE     = 4'd3;
    localparam logic [3:0] OP_ADD       = 4'd4;
    localparam logic [3:0] OP_SUB       = 4'd5;
    localparam logic [3:0] OP_AND       = 4'd6;
    localparam logic [3:0] OP_OR        = 4'd7;
    localparam logic [3:0] OP_XOR       = 4'd8;
    localparam logic [3:0] OP_NOT       = 4'd9;
    localparam logic [3:0] OP_LIN       = 4'd10;
    localparam logic [3:0] OP_PRINT     = 4'd11;
    localparam logic [3:0] OP_PRINT7SEG = 4'd12;
    localparam logic [3:0] OP_JMP       = 4'd13;
    localparam logic [3:0] OP_JZ        = 4'd14;
    localparam logic [3:0] OP_HALT      = 4'd15;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 8;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, HALT} state_t;

endpackage

// File: rtl/cpu_alu.sv
// Accumulator ALU: add/sub with carry-borrow, bitwise logic, not.
// Purely combinational, zero latency.
// No flow control.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        op,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
            OP_SUB: begin
                result = a - b;
                carry  = (a < b);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~b;
            default: ;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle 16-bit-instruction core: FETCH/DECODE/EXEC(/MEM) sequencing, register file, flags.
// 3 cycles per instruction, 4 for LOAD, LIN adds one cycle per cycle in_valid stays low.
// LIN stalls in EXEC until in_valid; in_ready pulses for the accepting cycle only.
module cpu_core
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int REG_N  = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic [7:0]        rom_addr,
    input  logic [15:0]       rom_data,
    output logic [7:0]        ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] led_out,
    output logic [15:0]       seg_out,
    output logic [7:0]        pc_out,
    output logic [DATA_W-1:0] acc_out,
    output logic              flag_z,
    output logic              flag_c,
    output logic              halted
);

    state_t            state, state_nxt;
    logic [7:0]        pc;
    logic [15:0]       ir;
    logic [DATA_W-1:0] regs [REG_N];

    logic [3:0]        ir_op, ir_rd;
    logic [7:0]        ir_imm;
    logic [DATA_W-1:0] imm_ext, rd_val, dec_val;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c, alu_z;
    logic              wb_en;
    logic [3:0]        wb_idx;
    logic [DATA_W-1:0] wb_dat;

    assign ir_op   = ir[OP_HI:OP_LO];
    assign ir_rd   = ir[RD_HI:RD_LO];
    assign ir_imm  = ir[IMM_HI:IMM_LO];
    assign imm_ext = DATA_W'(ir_imm);

    assign rom_addr = pc;
    assign pc_out   = pc;
    assign acc_out  = regs[0];

    // Out-of-range register indices match no entry, so they read as zero.
    always_comb begin
        rd_val  = '0;
        dec_val = '0;
        for (int i = 0; i < REG_N; i++) begin
            if (ir_rd == 4'(i))                  rd_val  = regs[i];
            if (rom_data[RD_HI:RD_LO] == 4'(i))  dec_val = regs[i];
        end
    end

    cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (regs[0]),
        .b      (rd_val),
        .op     (ir_op),
        .result (alu_res),
        .carry  (alu_c),
        .zero   (alu_z)
    );

    always_comb begin
        state_nxt = state;
        ram_we    = 1'b0;
        in_ready  = 1'b0;
        case (state)
            FETCH:  state_nxt = DECODE;
            DECODE: state_nxt = EXEC;
            EXEC: begin
                case (ir_op)
                    OP_LOAD:  state_nxt = MEM;
                    OP_LIN:   state_nxt = in_valid ? FETCH : EXEC;
                    OP_HALT:  state_nxt = HALT;
                    default:  state_nxt = FETCH;
                endcase
                ram_we   = (ir_op == OP_STORE) && !rst;
                in_ready = (ir_op == OP_LIN) && in_valid && !rst;
            end
            MEM:     state_nxt = FETCH;
            HALT:    state_nxt = HALT;
            default: state_nxt = FETCH;
        endcase
    end

    always_comb begin
        wb_en  = 1'b0;
        wb_idx = ir_rd;
        wb_dat = '0;
        if (state == EXEC) begin
            if (ir_op == OP_LI) begin
                wb_en  = 1'b1;
                wb_dat = imm_ext;
            end else if (ir_op inside {[OP_ADD:OP_NOT]}) begin
                wb_en  = 1'b1;
                wb_idx = 4'd0;
                wb_dat = alu_res;
            end else if (ir_op == OP_LIN) begin
                wb_en  = in_valid;
                wb_dat = in_data;
            end
        end else if (state == MEM) begin
            wb_en  = 1'b1;
            wb_dat = ram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_nxt;
    end

    // RAM address/data are captured at decode so STORE and LOAD present them throughout EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= 8'd0;
            ir        <= 16'd0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            led_out   <= '0;
            seg_out   <= 16'd0;
            halted    <= 1'b0;
            ram_addr  <= 8'd0;
            ram_wdata <= '0;
            for (int i = 0; i < REG_N; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < REG_N; i++)
                if (wb_en && wb_idx == 4'(i)) regs[i] <= wb_dat;
            case (state)
                DECODE: begin
                    ir        <= rom_data;
                    ram_addr  <= rom_data[IMM_HI:IMM_LO];
                    ram_wdata <= dec_val;
                end
                EXEC: begin
                    if (ir_op inside {[OP_ADD:OP_NOT]}) begin
                        flag_z <= alu_z;
                        flag_c <= alu_c;
                    end
                    case (ir_op)
                        OP_LOAD:      ;
                        OP_LIN:       if (in_valid) pc <= pc + 8'd1;
                        OP_PRINT:     begin led_out <= rd_val;      pc <= pc + 8'd1; end
                        OP_PRINT7SEG: begin seg_out <= 16'(rd_val); pc <= pc + 8'd1; end
                        OP_JMP:       pc <= ir_imm;
                        OP_JZ:        pc <= flag_z ? ir_imm : pc + 8'd1;
                        OP_HALT:      halted <= 1'b1;
                        default:      pc <= pc + 8'd1;
                    endcase
                end
                MEM:     pc <= pc + 8'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// Program-driven bench for cpu_core with behavioural ROM/RAM.
// RAM writes are checked against a queue of expected (addr, data) pairs.
module tb_cpu_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rom_addr, ram_addr, pc_out;
    logic [15:0] rom_data, seg_out;
    logic [7:0]  ram_wdata, ram_rdata, in_data, led_out, acc_out;
    logic        ram_we, in_valid, in_ready, flag_z, flag_c, halted;

    always #5 clk = ~clk;

    cpu_core #(.DATA_W(8), .REG_N(16)) dut (
        .clk(clk), .rst(rst),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .led_out(led_out), .seg_out(seg_out), .pc_out(pc_out), .acc_out(acc_out),
        .flag_z(flag_z), .flag_c(flag_c), .halted(halted)
    );

    logic [15:0] rom [256];
    logic [7:0]  ram [256];

    always @(posedge clk) rom_data <= rom[rom_addr];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
    wr_t wr_q[$];
    wr_t wr_e;

    int n_chk = 0;
    int n_pass = 0;
    int n_wr = 0;
    int n_rdy = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            n_wr++;
            if (wr_q.size() == 0) begin
                chk("ram_we_unexpected", 32'd1, 32'd0);
            end else begin
                wr_e = wr_q.pop_front();
                chk("ram_addr", 32'(ram_addr), 32'(wr_e.a));
                chk("ram_wdata", 32'(ram_wdata), 32'(wr_e.d));
            end
        end
        if (in_ready === 1'b1) n_rdy++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic begin_prog;
        rst = 1'b1;
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    task automatic go;
        tick(1);
        rst = 1'b0;
    endtask

    int bad;

    initial begin
        in_valid = 1'b0;
        in_data  = 8'h00;
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        begin_prog;
        tick(2);
        chk("rst_pc", 32'(pc_out), 32'h0);
        chk("rst_rom_addr", 32'(rom_addr), 32'h0);
        chk("rst_acc", 32'(acc_out), 32'h0);
        chk("rst_flags", 32'({flag_z, flag_c}), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_led", 32'(led_out), 32'h0);
        chk("rst_seg", 32'(seg_out), 32'h0);
        chk("rst_we_rdy", 32'({ram_we, in_ready}), 32'h0);

        // ADD with carry out and zero result
        begin_prog;
        rom[0] = 16'h100F; rom[1] = 16'h11F1; rom[2] = 16'h4100;
        go;
        tick(9);
        chk("add_acc", 32'(acc_out), 32'h00);
        chk("add_z", 32'(flag_z), 32'h1);
        chk("add_c", 32'(flag_c), 32'h1);
        chk("add_pc", 32'(pc_out), 32'h3);

        // SUB with borrow, JZ not taken
        begin_prog;
        rom[0] = 16'h1005; rom[1] = 16'h1207; rom[2] = 16'h5200; rom[3] = 16'hE020;
        go;
        tick(9);
        chk("sub_acc", 32'(acc_out), 32'hFE);
        chk("sub_c", 32'(flag_c), 32'h1);
        chk("sub_z", 32'(flag_z), 32'h0);
        tick(3);
        chk("jz_not_taken_pc", 32'(pc_out), 32'h4);

        // STORE / LOAD / PRINT, then HALT
        begin_prog;
        rom[0] = 16'h13A5; rom[1] = 16'h3310; rom[2] = 16'h2410; rom[3] = 16'hB400; rom[4] = 16'hF000;
        wr_q.push_back('{8'h10, 8'hA5});
        n_wr = 0;
        go;
        tick(9);
        chk("load_exec_pc", 32'(pc_out), 32'h2);
        tick(1);
        chk("load_mem_pc", 32'(pc_out), 32'h3);
        tick(3);
        chk("print_led", 32'(led_out), 32'hA5);
        chk("print_pc", 32'(pc_out), 32'h4);
        chk("store_pulses", 32'(n_wr), 32'd1);
        tick(3);
        chk("halt_flag", 32'(halted), 32'h1);
        chk("halt_pc", 32'(pc_out), 32'h4);
        bad = 0;
        repeat (20) begin
            tick(1);
            if (pc_out !== 8'h04 || halted !== 1'b1 || led_out !== 8'hA5) bad++;
        end
        chk("halt_freeze", 32'(bad), 32'd0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("halt_rst_pc", 32'(pc_out), 32'h0);
        chk("halt_rst_halted", 32'(halted), 32'h0);

        // LIN wait then accept
        begin_prog;
        rom[0] = 16'hA500; rom[1] = 16'hB500; rom[2] = 16'hF000;
        n_rdy = 0;
        go;
        tick(2);
        bad = 0;
        repeat (10) begin
            tick(1);
            if (in_ready !== 1'b0 || pc_out !== 8'h00) bad++;
        end
        chk("lin_wait", 32'(bad), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h3C;
        #1;
        chk("lin_ready", 32'(in_ready), 32'h1);
        tick(1);
        in_valid = 1'b0;
        in_data  = 8'hFF;
        #1;
        chk("lin_pc", 32'(pc_out), 32'h1);
        chk("lin_ready_low", 32'(in_ready), 32'h0);
        chk("lin_pulses", 32'(n_rdy), 32'd1);
        tick(3);
        chk("lin_led", 32'(led_out), 32'h3C);

        // PC wrap 0xFF -> 0x00
        begin_prog;
        rom[0] = 16'hD0FF;
        go;
        tick(3);
        chk("jmp_pc", 32'(pc_out), 32'hFF);
        tick(3);
        chk("wrap_pc", 32'(pc_out), 32'h00);

        // reset on the STORE EXEC edge suppresses the write
        begin_prog;
        rom[0] = 16'h1177; rom[1] = 16'h3130; rom[2] = 16'hF000;
        n_wr = 0;
        go;
        tick(5);
        rst = 1'b1;
        #1;
        chk("rst_store_we", 32'(ram_we), 32'h0);
        tick(1);
        chk("rst_store_pc", 32'(pc_out), 32'h0);
        chk("rst_store_ram", 32'(ram[8'h30]), 32'h00);
        chk("rst_store_pulses", 32'(n_wr), 32'd0);
        tick(2);

        chk("wr_q_empty", 32'(wr_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cpu_core.md
# cpu_core

Parametrised multi-cycle processor core: the next-generation control/datapath block for the 16-bit-instruction board processor. It fetches from a synchronous program ROM, sequences each instruction through an explicit FSM, and owns the register file and flags. It also drives the data RAM, the switch input (with valid/ready handshake), the LED output and the 7-segment value output. It replaces the single-cycle combinational decoder and adds conditional branching, carry/zero flags, HALT and a blocking input.

## Interface
- DATA_W, 8, datapath/register/RAM word width (8..16)
- REG_N, 16, number of registers (2..16); R0 is the accumulator
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- rom_addr  out  8  program address (= PC)
- rom_data  in  16  instruction; valid one cycle after rom_addr
- ram_addr  out  8  data RAM address
- ram_wdata  out  DATA_W  write data
- ram_we  out  1  write strobe
- ram_rdata  in  DATA_W  read data; valid one cycle after ram_addr
- in_data  in  DATA_W  external input word
- in_valid  in  1  in_data valid
- in_ready  out  1  one-cycle accept pulse
- led_out  out  DATA_W  PRINT register
- seg_out  out  16  PRINT7SEG register, zero-extended or truncated to 16 bits
- pc_out  out  8  current PC
- acc_out  out  DATA_W  R0
- flag_z, flag_c  out  1 each  zero and carry flags
- halted  out  1  core stopped

## Operation
- Instruction fields: [15:12] opcode, [11:8] rd, [7:0] imm/addr. Immediates are zero-extended to DATA_W.
- Register rd ≥ REG_N: writes are ignored; reads return 0.
- Opcodes:
  - 0 NOP
  - 1 LI: R[rd] ← imm
  - 2 LOAD: R[rd] ← RAM[addr]
  - 3 STORE: RAM[addr] ← R[rd]
  - 4 ADD: R0 ← R0 + R[rd]
  - 5 SUB: R0 ← R0 − R[rd]
  - 6 AND, 7 OR, 8 XOR: R0 ← R0 op R[rd]
  - 9 NOT: R0 ← ~R[rd]
  - 10 LIN: R[rd] ← in_data
  - 11 PRINT: led_out ← R[rd]
  - 12 PRINT7SEG: seg_out ← R[rd]
  - 13 JMP: PC ← imm
  - 14 JZ: if flag_z, PC ← imm
  - 15 HALT
- Flags are updated only by opcodes 4–9.
  - Z = (result == 0).
  - ADD: C = carry out of bit DATA_W−1.
  - SUB: C = borrow, i.e. R0 < R[rd] unsigned.
  - Logic ops clear C.
- FSM states:
  - FETCH: rom_addr = PC. Go to DECODE.
  - DECODE: IR ← rom_data. Go to EXEC.
  - EXEC:
    - Executes the instruction.
    - LOAD drives ram_addr and goes to MEM.
    - LIN stays in EXEC until in_valid=1.
    - HALT goes to HALT.
    - All others update PC and go to FETCH.
  - MEM: R[rd] ← ram_rdata; PC+1; go to FETCH.
  - HALT: halted=1. PC, registers and outputs are frozen. Left only by rst.
- PC update: PC+1 mod 256, or the branch target. 0xFF+1 → 0x00.
- STORE: ram_we=1 for exactly the EXEC cycle, with ram_addr=addr and ram_wdata=R[rd]. ram_we is 0 in all other cycles.
- LIN: in_ready=1 combinationally in EXEC of LIN when in_valid=1. The register is written on that edge. in_data is ignored at all other times.

## Timing
- Cycles per instruction: 3 for most; 4 for LOAD; LIN takes 3 + wait cycles.
- After rst deasserts, the first FETCH occurs in the first cycle.
- Results (registers, flags, led_out, seg_out, PC) are visible the cycle after the edge that ends EXEC or MEM.
- Reset values: state=FETCH, PC=0, all registers 0, IR=0, flags 0, led_out=0, seg_out=0, halted=0, ram_we=0, in_ready=0.
- rst dominates every state, including mid-LOAD, mid-LIN wait and HALT.
- A STORE whose EXEC edge coincides with rst=1 is suppressed: ram_we is gated by !rst.
- Combinational outputs: in_ready and ram_we. All other outputs are registered.

## Structure
- Package cpu_pkg holds:
  - opcode localparams
  - the state enum {FETCH, DECODE, EXEC, MEM, HALT}
  - instruction field bit positions
- Sub-module cpu_alu: combinational, parametrised by DATA_W. Inputs a, b, op. Outputs result, carry, zero.
- The register file stays inside cpu_core as an array of REG_N×DATA_W.

## Test plan
All scenarios use DATA_W=8 and REG_N=16.
- LI R0,0x0F; LI R1,0xF1; ADD R1 → R0=0x00, flag_z=1, flag_c=1, pc_out=3 after 9 cycles.
- LI R0,5; LI R2,7; SUB R2; JZ 0x20 → R0=0xFE, flag_c=1, flag_z=0, branch not taken, PC=4.
- LI R3,0xA5; STORE R3,0x10; LOAD R4,0x10; PRINT R4:
  - Exactly one ram_we pulse, with ram_addr=0x10 and ram_wdata=0xA5.
  - LOAD takes 4 cycles; R4=0xA5.
  - led_out=0xA5.
- LIN R5 with in_valid=0 for 10 cycles → PC holds, in_ready=0 throughout. Then in_valid=1, in_data=0x3C → single in_ready pulse, R5=0x3C, PC advances.
- JMP 0xFF with NOP at 0xFF → PC wraps to 0x00.
- HALT → halted=1, pc_out frozen for 20 cycles. Then rst for 1 cycle → pc_out=0, halted=0. rst asserted during a STORE EXEC → no RAM write.
